a25_exception_sequencer: RTL and testbench

- Arbitrates exception/interrupt requests (dabt, firq, irq, iabt, adex) and offers one vector to the a25 decode stage at a time using a valid/ack handshake.
- Latches pulsed abort/exception events until serviced, applies the irq/firq masks from the status bits, and enforces a minimum gap between grants.
- Sits beside a25_decode in the core and drives its interrupt vector selection.

---
 rtl/a25_exc_pkg.sv | 39 +++
 rtl/a25_exc_priority_enc.sv | 25 ++
 rtl/a25_exception_sequencer.sv | 168 ++++++++++++++++
 tb/tb_a25_exception_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/a25_exc_pkg.sv
// Shared types and constants for the a25 exception sequencer.
// States, vector codes and pending-source bit positions.
package a25_exc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OFFER,
    GAP
  } state_t;

  localparam logic [2:0] VEC_IABT = 3'd3;
  localparam logic [2:0] VEC_DABT = 3'd4;
  localparam logic [2:0] VEC_ADEX = 3'd5;
  localparam logic [2:0] VEC_IRQ  = 3'd6;
  localparam logic [2:0] VEC_FIRQ = 3'd7;

  localparam int SRC_ADEX = 0;
  localparam int SRC_IABT = 1;
  localparam int SRC_DABT = 2;
  localparam int SRC_IRQ  = 3;
  localparam int SRC_FIRQ = 4;

  // Map a vector code back to its pending-bit index.
  function automatic logic [2:0] vec2src(
    input logic [2:0] v
  );
    logic [2:0] s;
    s = 3'(SRC_ADEX);
    case (v)
      VEC_IABT: s = 3'(SRC_IABT);
      VEC_DABT: s = 3'(SRC_DABT);
      VEC_IRQ:  s = 3'(SRC_IRQ);
      VEC_FIRQ: s = 3'(SRC_FIRQ);
      default:  s = 3'(SRC_ADEX);
    endcase
    return s;
  endfunction

endpackage

// File: rtl/a25_exc_priority_enc.sv
// Fixed-priority encoder: pending sources to vector code.
// Order is dabt > firq > irq > iabt > adex.
module a25_exc_priority_enc
  import a25_exc_pkg::*;
(
  input  logic [4:0] pending,
  output logic [2:0] code,
  output logic       vld
);

  // Highest-priority pending source wins.
  always_comb begin
    code = '0;
    vld  = |pending;
    priority case (1'b1)
      pending[SRC_DABT]: code = VEC_DABT;
      pending[SRC_FIRQ]: code = VEC_FIRQ;
      pending[SRC_IRQ]:  code = VEC_IRQ;
      pending[SRC_IABT]: code = VEC_IABT;
      pending[SRC_ADEX]: code = VEC_ADEX;
      default:           code = '0;
    endcase
  end

endmodule

// File: rtl/a25_exception_sequencer.sv
// Exception/interrupt sequencer offering one vector at a time.
// Optional per-cause grant counters under A25_EXC_STATS_EN.
module a25_exception_sequencer
  import a25_exc_pkg::*;
#(
  parameter int MIN_GAP = 2,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_core_stall,
  input  logic       i_irq,
  input  logic       i_firq,
  input  logic       i_dabt,
  input  logic       i_iabt,
  input  logic       i_adex,
  input  logic       i_irq_mask,
  input  logic       i_firq_mask,
  input  logic       i_ack,
  output logic       o_req,
  output logic [2:0] o_vector_sel,
  output logic [4:0] o_pending,
  output logic       o_busy
`ifdef A25_EXC_STATS_EN
  ,
  output logic [5*CNT_W-1:0] o_stat_count
`endif
);

  state_t     state;
  logic [3:0] gap_cnt;
  logic [2:0] sticky;
  logic [2:0] clr;
  logic [2:0] win_code;
  logic       win_vld;
  logic       offer_lvl;
  logic       withdraw;
  logic       accept;

  assign o_pending = {
    i_firq & ~i_firq_mask,
    i_irq & ~i_irq_mask,
    sticky
  };

  a25_exc_priority_enc u_enc (
    .pending (o_pending),
    .code    (win_code),
    .vld     (win_vld)
  );

  // Level sources lose their offer once no longer eligible.
  always_comb begin
    offer_lvl = 1'b0;
    withdraw  = 1'b0;
    if (o_vector_sel == VEC_FIRQ) begin
      offer_lvl = 1'b1;
      withdraw  = ~o_pending[SRC_FIRQ];
    end else if (o_vector_sel == VEC_IRQ) begin
      offer_lvl = 1'b1;
      withdraw  = ~o_pending[SRC_IRQ];
    end
    withdraw = withdraw & offer_lvl
             & (state == OFFER);
  end

  assign accept = (state == OFFER)
                & i_ack & ~i_core_stall
                & ~withdraw;

  // Sticky clear for the accepted pulsed source.
  always_comb begin
    clr = '0;
    if (accept) begin
      case (o_vector_sel)
        VEC_DABT: clr[SRC_DABT] = 1'b1;
        VEC_IABT: clr[SRC_IABT] = 1'b1;
        VEC_ADEX: clr[SRC_ADEX] = 1'b1;
        default:  clr = '0;
      endcase
    end
  end

  // Latch pulsed events; a new pulse beats a clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sticky <= '0;
    end else begin
      sticky <= (sticky & ~clr)
              | {i_dabt, i_iabt, i_adex};
    end
  end

  // Offer / gap sequencing with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      gap_cnt      <= '0;
      o_req        <= 1'b0;
      o_vector_sel <= '0;
      o_busy       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (win_vld && !i_core_stall) begin
            o_vector_sel <= win_code;
            o_req        <= 1'b1;
            o_busy       <= 1'b1;
            state        <= OFFER;
          end
        end
        OFFER: begin
          if (withdraw) begin
            o_req  <= 1'b0;
            o_busy <= 1'b0;
            state  <= IDLE;
          end else if (accept) begin
            o_req <= 1'b0;
            if (MIN_GAP == 0) begin
              o_busy <= 1'b0;
              state  <= IDLE;
            end else begin
              gap_cnt <= 4'(MIN_GAP);
              state   <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt <= 4'd1) begin
            o_busy <= 1'b0;
            state  <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: begin
          o_req  <= 1'b0;
          o_busy <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

`ifdef A25_EXC_STATS_EN
  logic [2:0] acc_src;

  assign acc_src = vec2src(o_vector_sel);

  for (genvar g = 0; g < 5; g++) begin : g_stat
    logic [CNT_W-1:0] cnt;

    // Saturating count of accepted grants.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt <= '0;
      end else if (accept
                   && acc_src == 3'(g)
                   && cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
    end

    assign o_stat_count[g*CNT_W +: CNT_W] = cnt;
  end
`endif

endmodule

// File: tb/tb_a25_exception_sequencer.sv
// Self-checking bench for a25_exception_sequencer.
// Directed steps then random traffic against a cycle model.
module tb_a25_exception_sequencer;

  localparam int MG = 2;
`ifdef A25_EXC_STATS_EN
  localparam int CW = 2;
`else
  localparam int CW = 8;
`endif
  localparam int SAT = (1 << CW) - 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_core_stall;
  logic       i_irq, i_firq;
  logic       i_dabt, i_iabt, i_adex;
  logic       i_irq_mask, i_firq_mask;
  logic       i_ack;
  logic       o_req;
  logic [2:0] o_vector_sel;
  logic [4:0] o_pending;
  logic       o_busy;
`ifdef A25_EXC_STATS_EN
  logic [5*CW-1:0] o_stat_count;
`endif

  always #5 clk = ~clk;

  a25_exception_sequencer #(
    .MIN_GAP (MG),
    .CNT_W   (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_core_stall (i_core_stall),
    .i_irq        (i_irq),
    .i_firq       (i_firq),
    .i_dabt       (i_dabt),
    .i_iabt       (i_iabt),
    .i_adex       (i_adex),
    .i_irq_mask   (i_irq_mask),
    .i_firq_mask  (i_firq_mask),
    .i_ack        (i_ack),
    .o_req        (o_req),
    .o_vector_sel (o_vector_sel),
    .o_pending    (o_pending),
    .o_busy       (o_busy)
`ifdef A25_EXC_STATS_EN
    ,
    .o_stat_count (o_stat_count)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: source index 0 adex,1 iabt,2 dabt,3 irq,4 firq
  int pri_src[5] = '{2, 4, 3, 1, 0};
  int vec_of[5]  = '{5, 3, 4, 6, 7};
  logic [2:0] m_st;
  int m_mode;
  int m_src;
  int m_code;
  int m_gap;
  int m_stat[5];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] m_pend();
    return {i_firq & ~i_firq_mask,
            i_irq & ~i_irq_mask, m_st};
  endfunction

  task automatic model_reset();
    m_st   = '0;
    m_mode = 0;
    m_src  = 0;
    m_code = 0;
    m_gap  = 0;
    for (int s = 0; s < 5; s++) m_stat[s] = 0;
  endtask

  task automatic model_edge();
    logic [4:0] el;
    logic [2:0] clr;
    bit found;
    el = m_pend();
    clr = '0;
    found = 0;
    if (!reset) begin
      model_reset();
      return;
    end
    case (m_mode)
      0: if (el != 0 && !i_core_stall) begin
        for (int k = 0; k < 5; k++)
          if (!found && el[pri_src[k]]) begin
            found = 1;
            m_src = pri_src[k];
          end
        m_code = vec_of[m_src];
        m_mode = 1;
      end
      1: if (m_src >= 3 && !el[m_src]) begin
        m_mode = 0;
      end else if (i_ack && !i_core_stall) begin
        if (m_src < 3) clr[m_src] = 1'b1;
        if (m_stat[m_src] < SAT) m_stat[m_src]++;
        m_gap  = MG;
        m_mode = (MG == 0) ? 0 : 2;
      end
      default: begin
        m_gap--;
        if (m_gap == 0) m_mode = 0;
      end
    endcase
    m_st = (m_st & ~clr) | {i_dabt, i_iabt, i_adex};
  endtask

  task automatic tick();
    @(negedge clk);
    chk("pending", 32'(o_pending), 32'(m_pend()));
    @(posedge clk);
    model_edge();
    #1;
    chk("req", 32'(o_req), 32'(m_mode == 1));
    chk("sel", 32'(o_vector_sel), 32'(m_code));
    chk("busy", 32'(o_busy), 32'(m_mode != 0));
`ifdef A25_EXC_STATS_EN
    for (int s = 0; s < 5; s++)
      chk("stat", 32'(o_stat_count[s*CW +: CW]),
          32'(m_stat[s]));
`endif
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset = 1'b0;
    i_core_stall = 0; i_irq = 0; i_firq = 0;
    i_dabt = 0; i_iabt = 0; i_adex = 0;
    i_irq_mask = 0; i_firq_mask = 0; i_ack = 0;
    model_reset();
    ticks(2);
    chk("rst_req", 32'(o_req), 0);
    chk("rst_sel", 32'(o_vector_sel), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_pend", 32'(o_pending), 0);
    reset = 1'b1;
    tick();

    // dabt pulse, offer, ack, gap
    i_dabt = 1; tick(); i_dabt = 0;
    chk("dabt_noreq", 32'(o_req), 0);
    tick();
    chk("dabt_req", 32'(o_req), 1);
    chk("dabt_sel", 32'(o_vector_sel), 4);
    i_ack = 1; tick(); i_ack = 0;
    chk("dabt_ack_req", 32'(o_req), 0);
    chk("dabt_clr", 32'(o_pending[2]), 0);
    chk("dabt_gap1", 32'(o_busy), 1);
    tick();
    chk("dabt_gap2", 32'(o_busy), 1);
    tick();
    chk("dabt_idle", 32'(o_busy), 0);

    // firq beats irq, irq follows after gap
    i_irq = 1; i_firq = 1; tick();
    chk("firq_sel", 32'(o_vector_sel), 7);
    i_ack = 1; tick(); i_ack = 0; i_firq = 0;
    ticks(3);
    chk("irq_sel", 32'(o_vector_sel), 6);
    chk("irq_req", 32'(o_req), 1);
    i_ack = 1; tick(); i_ack = 0; i_irq = 0;
    ticks(3);

    // irq withdrawn by mask
    i_irq = 1; tick();
    chk("wd_sel", 32'(o_vector_sel), 6);
    i_irq_mask = 1; tick();
    chk("wd_req", 32'(o_req), 0);
    chk("wd_busy", 32'(o_busy), 0);
    i_irq = 0; i_irq_mask = 0; tick();

    // stall blocks offer and ack
    i_core_stall = 1; i_dabt = 1; tick(); i_dabt = 0;
    ticks(2);
    chk("stl_noreq", 32'(o_req), 0);
    i_core_stall = 0; tick();
    chk("stl_sel", 32'(o_vector_sel), 4);
    i_core_stall = 1; i_ack = 1; tick();
    chk("stl_hold", 32'(o_req), 1);
    i_core_stall = 0; tick(); i_ack = 0;
    chk("stl_acc", 32'(o_req), 0);
    ticks(2);

    // no preemption; set beats clear
    i_iabt = 1; tick(); i_iabt = 0; tick();
    chk("iabt_sel", 32'(o_vector_sel), 3);
    i_dabt = 1; tick(); i_dabt = 0;
    chk("nopre_sel", 32'(o_vector_sel), 3);
    i_ack = 1; i_iabt = 1; tick();
    i_ack = 0; i_iabt = 0;
    chk("iabt_keep", 32'(o_pending[1]), 1);
    ticks(3);
    chk("dabt_next", 32'(o_vector_sel), 4);
    i_ack = 1; tick(); i_ack = 0;
    ticks(3);
    chk("iabt_next", 32'(o_vector_sel), 3);
    i_ack = 1; tick(); i_ack = 0;
    i_adex = 1; ticks(2); i_adex = 0;
    tick();
    ticks(2);
    chk("adex_sel", 32'(o_vector_sel), 5);
    i_ack = 1; tick(); i_ack = 0;
    ticks(3);

    // async reset mid-offer
    i_dabt = 1; tick(); i_dabt = 0; tick();
    chk("mid_req", 32'(o_req), 1);
    reset = 0;
    #1;
    model_reset();
    chk("ar_req", 32'(o_req), 0);
    chk("ar_sel", 32'(o_vector_sel), 0);
    chk("ar_busy", 32'(o_busy), 0);
    chk("ar_pend", 32'(o_pending), 0);
    tick();
    reset = 1;
    tick();

    // five dabt grants
    for (int g = 0; g < 5; g++) begin
      i_dabt = 1; tick(); i_dabt = 0; tick();
      i_ack = 1; tick(); i_ack = 0;
      ticks(2);
    end
`ifdef A25_EXC_STATS_EN
    chk("stat_sat", 32'(o_stat_count[2*CW +: CW]), 3);
`endif

    // random traffic
    for (int c = 0; c < 800; c++) begin
      i_core_stall = ($urandom_range(3) == 0);
      if ($urandom_range(7) == 0) i_irq = ~i_irq;
      if ($urandom_range(9) == 0) i_firq = ~i_firq;
      if ($urandom_range(15) == 0)
        i_irq_mask = ~i_irq_mask;
      if ($urandom_range(15) == 0)
        i_firq_mask = ~i_firq_mask;
      i_dabt = ($urandom_range(9) == 0);
      i_iabt = ($urandom_range(9) == 0);
      i_adex = ($urandom_range(9) == 0);
      i_ack  = ($urandom_range(1) == 0);
      tick();
    end
    i_core_stall = 0; i_irq = 0; i_firq = 0;
    i_dabt = 0; i_iabt = 0; i_adex = 0; i_ack = 0;
    ticks(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
